alu_wide_sequencer: RTL and testbench

Two-pass controller that performs 64-bit arithmetic and logic operations on the 32-bit execute-stage ALU. It accepts one 64-bit request over a valid/ready handshake and drives the ALU's operand, command and carry inputs for the low word and then the high word. It chains the carry between the two passes, merges the flags and returns a 64-bit result with NZCV over a second valid/ready handshake. It sits beside the execute stage and owns the ALU ports while busy.

---
 rtl/alu_wide_sequencer_pkg.sv | 73 +++++++
 rtl/alu_wide_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_wide_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wide_sequencer_pkg.sv
// alu_wide_sequencer_pkg
// Shared definitions for the two-pass 64-bit ALU sequencer:
//   - request op encodings (3 bits)
//   - execute-stage ALU command codes (4 bits)
//   - bit positions inside a {N,Z,C,V} status nibble
//   - sequencer state encoding
//   - helpers that map a request op onto the ALU command for each pass
package alu_wide_sequencer_pkg;

  // Request op encodings
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_MVN = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  // Execute-stage ALU commands
  localparam logic [3:0] CMD_NONE = 4'b0000;
  localparam logic [3:0] CMD_MOV  = 4'b0001;
  localparam logic [3:0] CMD_ADD  = 4'b0010;
  localparam logic [3:0] CMD_ADC  = 4'b0011;
  localparam logic [3:0] CMD_SUB  = 4'b0100;
  localparam logic [3:0] CMD_SBC  = 4'b0101;
  localparam logic [3:0] CMD_AND  = 4'b0110;
  localparam logic [3:0] CMD_ORR  = 4'b0111;
  localparam logic [3:0] CMD_EOR  = 4'b1000;
  localparam logic [3:0] CMD_MVN  = 4'b1001;

  // Bit positions inside a {N,Z,C,V} status nibble
  localparam int unsigned ST_N = 3;
  localparam int unsigned ST_Z = 2;
  localparam int unsigned ST_C = 1;
  localparam int unsigned ST_V = 0;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LO   = 2'b01,
    S_HI   = 2'b10,
    S_DONE = 2'b11
  } seq_state_t;

  // ALU command for the low-word pass (no carry chaining yet)
  function automatic logic [3:0] lo_cmd(input logic [2:0] op);
    logic [3:0] cmd;
    case (op)
      OP_ADD:  cmd = CMD_ADD;
      OP_SUB:  cmd = CMD_SUB;
      OP_AND:  cmd = CMD_AND;
      OP_ORR:  cmd = CMD_ORR;
      OP_EOR:  cmd = CMD_EOR;
      OP_MOV:  cmd = CMD_MOV;
      OP_MVN:  cmd = CMD_MVN;
      default: cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

  // ALU command for the high-word pass: arithmetic switches to its carry-chained form
  function automatic logic [3:0] hi_cmd(input logic [2:0] op);
    logic [3:0] cmd;
    case (op)
      OP_ADD:  cmd = CMD_ADC;
      OP_SUB:  cmd = CMD_SBC;
      default: cmd = lo_cmd(op);
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer
// Runs one 64-bit operation as two passes through the shared 32-bit execute
// ALU: low word first, then high word with the carry chained in. Flags of the
// two passes are merged into a single 64-bit NZCV result.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake; req_op, req_a, req_b payload
//   rsp_valid/rsp_ready      response handshake; rsp_result, rsp_status {N,Z,C,V},
//                            rsp_err (reserved op requested)
//   alu_in1/alu_in2/alu_carry_in/alu_exe_cmd   drive the external ALU
//   alu_result/alu_status    combinational answer from the external ALU
module alu_wide_sequencer
  import alu_wide_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic [3:0]  rsp_status,
  output logic        rsp_err,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic        alu_carry_in,
  output logic [3:0]  alu_exe_cmd,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_status
);

  seq_state_t  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        c_lo_q, c_lo_d;
  logic        z_lo_q, z_lo_d;
  logic [63:0] rsp_result_q, rsp_result_d;
  logic [3:0]  rsp_status_q, rsp_status_d;
  logic        rsp_err_q, rsp_err_d;

  logic        accept_s;
  logic        op_rsv_s;

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_result = rsp_result_q;
  assign rsp_status = rsp_status_q;
  assign rsp_err    = rsp_err_q;

  assign accept_s = req_valid && req_ready;
  assign op_rsv_s = (op_q == OP_RSV);

  // ALU drive: operands and command follow the current pass, zero otherwise
  always_comb begin
    alu_in1      = 32'h0000_0000;
    alu_in2      = 32'h0000_0000;
    alu_carry_in = 1'b0;
    alu_exe_cmd  = CMD_NONE;
    case (state_q)
      S_LO: begin
        alu_in1     = a_q[31:0];
        alu_in2     = b_q[31:0];
        alu_exe_cmd = lo_cmd(op_q);
      end
      S_HI: begin
        alu_in1     = a_q[63:32];
        alu_in2     = b_q[63:32];
        alu_exe_cmd = hi_cmd(op_q);
        // The ALU reports raw borrow on subtract, while SBC expects a
        // "no-borrow" carry input, hence the inversion for SUB.
        if (op_q == OP_ADD) begin
          alu_carry_in = c_lo_q;
        end else if (op_q == OP_SUB) begin
          alu_carry_in = ~c_lo_q;
        end else begin
          alu_carry_in = 1'b0;
        end
      end
      default: begin
        alu_exe_cmd = CMD_NONE;
      end
    endcase
  end

  // Next-state, request capture, low-pass capture and response merge
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_lo_d     = res_lo_q;
    c_lo_d       = c_lo_q;
    z_lo_d       = z_lo_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          state_d = S_LO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LO: begin
        res_lo_d = alu_result;
        c_lo_d   = alu_status[ST_C];
        z_lo_d   = alu_status[ST_Z];
        state_d  = S_HI;
      end
      S_HI: begin
        if (op_rsv_s) begin
          rsp_result_d = 64'h0000_0000_0000_0000;
          rsp_status_d = 4'b0100;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = {alu_result, res_lo_q};
          rsp_status_d = {alu_status[ST_N], z_lo_q & alu_status[ST_Z],
                          alu_status[ST_C], alu_status[ST_V]};
          rsp_err_d    = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 3'b000;
      a_q          <= 64'h0000_0000_0000_0000;
      b_q          <= 64'h0000_0000_0000_0000;
      res_lo_q     <= 32'h0000_0000;
      c_lo_q       <= 1'b0;
      z_lo_q       <= 1'b0;
      rsp_result_q <= 64'h0000_0000_0000_0000;
      rsp_status_q <= 4'b0000;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_lo_q     <= res_lo_d;
      c_lo_q       <= c_lo_d;
      z_lo_q       <= z_lo_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb_alu_wide_sequencer
// Directed bench for alu_wide_sequencer. A behavioural execute-stage ALU is
// attached to the alu_* ports (subtract reports raw borrow in C, SBC takes a
// "no-borrow" carry input). Expected results are hand-computed constants.
module tb_alu_wide_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_status;
  logic        rsp_err;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        alu_carry_in;
  logic [3:0]  alu_exe_cmd;
  logic [31:0] alu_result;
  logic [3:0]  alu_status;

  int checks_cnt;
  int fail_cnt;

  alu_wide_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_status   (rsp_status),
    .rsp_err      (rsp_err),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_carry_in (alu_carry_in),
    .alu_exe_cmd  (alu_exe_cmd),
    .alu_result   (alu_result),
    .alu_status   (alu_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural execute-stage ALU
  always_comb begin
    logic [32:0] t33;
    logic        c;
    logic        v;
    t33        = 33'd0;
    c          = 1'b0;
    v          = 1'b0;
    alu_result = 32'h0000_0000;
    case (alu_exe_cmd)
      4'b0001: alu_result = alu_in2;
      4'b0010, 4'b0011: begin
        t33 = {1'b0, alu_in1} + {1'b0, alu_in2} +
              {32'd0, (alu_exe_cmd == 4'b0011) ? alu_carry_in : 1'b0};
        alu_result = t33[31:0];
        c = t33[32];
        v = (alu_in1[31] == alu_in2[31]) && (alu_result[31] != alu_in1[31]);
      end
      4'b0100, 4'b0101: begin
        t33 = {1'b0, alu_in1} - {1'b0, alu_in2} -
              {32'd0, (alu_exe_cmd == 4'b0101) ? ~alu_carry_in : 1'b0};
        alu_result = t33[31:0];
        c = t33[32];
        v = (alu_in1[31] != alu_in2[31]) && (alu_result[31] != alu_in1[31]);
      end
      4'b0110: alu_result = alu_in1 & alu_in2;
      4'b0111: alu_result = alu_in1 | alu_in2;
      4'b1000: alu_result = alu_in1 ^ alu_in2;
      4'b1001: alu_result = ~alu_in2;
      default: alu_result = 32'h0000_0000;
    endcase
    alu_status = {alu_result[31], (alu_result == 32'h0000_0000), c, v};
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one request from IDLE to DONE, checking each pass and the response.
  // With do_ack the response is taken and the return to IDLE is checked.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] exp_lo_cmd, input logic [3:0] exp_hi_cmd,
                        input logic exp_hi_cin, input logic [63:0] exp_res,
                        input logic [3:0] exp_st, input logic exp_err,
                        input logic do_ack);
    check_val({tag, ".idle_ready"}, {63'd0, req_ready}, 64'd1);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check_val({tag, ".lo_cmd"}, {60'd0, alu_exe_cmd}, {60'd0, exp_lo_cmd});
    check_val({tag, ".lo_cin"}, {63'd0, alu_carry_in}, 64'd0);
    check_val({tag, ".lo_in1"}, {32'd0, alu_in1}, {32'd0, a[31:0]});
    check_val({tag, ".lo_busy"}, {63'd0, req_ready}, 64'd0);
    step();
    check_val({tag, ".hi_cmd"}, {60'd0, alu_exe_cmd}, {60'd0, exp_hi_cmd});
    check_val({tag, ".hi_cin"}, {63'd0, alu_carry_in}, {63'd0, exp_hi_cin});
    check_val({tag, ".hi_in2"}, {32'd0, alu_in2}, {32'd0, b[63:32]});
    step();
    check_val({tag, ".rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
    check_val({tag, ".result"}, rsp_result, exp_res);
    check_val({tag, ".status"}, {60'd0, rsp_status}, {60'd0, exp_st});
    check_val({tag, ".err"}, {63'd0, rsp_err}, {63'd0, exp_err});
    check_val({tag, ".done_cmd"}, {60'd0, alu_exe_cmd}, 64'd0);
    if (do_ack) begin
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check_val({tag, ".ack_valid"}, {63'd0, rsp_valid}, 64'd0);
      check_val({tag, ".ack_ready"}, {63'd0, req_ready}, 64'd1);
    end
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 3'b000;
    req_a      = 64'd0;
    req_b      = 64'd0;
    rsp_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    check_val("reset.rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_val("reset.req_ready", {63'd0, req_ready}, 64'd1);
    check_val("reset.result", rsp_result, 64'd0);
    check_val("reset.status", {60'd0, rsp_status}, 64'd0);
    check_val("reset.cmd", {60'd0, alu_exe_cmd}, 64'd0);

    run_op("add_carry", 3'b000, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001,
           4'b0010, 4'b0011, 1'b1, 64'h0000_0001_0000_0000, 4'b0000, 1'b0, 1'b1);
    run_op("sub_borrow", 3'b001, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001,
           4'b0100, 4'b0101, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'b0000, 1'b0, 1'b1);
    run_op("sub_zero", 3'b001, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
           4'b0100, 4'b0101, 1'b1, 64'h0000_0000_0000_0000, 4'b0100, 1'b0, 1'b1);
    run_op("eor", 3'b100, 64'hF0F0_F0F0_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF,
           4'b1000, 4'b1000, 1'b0, 64'h0F0F_0F0F_F0F0_F0F0, 4'b0000, 1'b0, 1'b1);
    run_op("mvn", 3'b110, 64'h1111_2222_3333_4444, 64'h0000_0000_0000_0000,
           4'b1001, 4'b1001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0, 1'b1);

    // Signed overflow, then hold the response while a second request waits
    run_op("add_ovf", 3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001,
           4'b0010, 4'b0011, 1'b1, 64'h8000_0000_0000_0000, 4'b1001, 1'b0, 1'b0);
    req_op    = 3'b111;
    req_a     = 64'hDEAD_BEEF_0000_0001;
    req_b     = 64'h0000_0001_CAFE_F00D;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("stall.valid", {63'd0, rsp_valid}, 64'd1);
      check_val("stall.result", rsp_result, 64'h8000_0000_0000_0000);
      check_val("stall.status", {60'd0, rsp_status}, 64'h9);
      check_val("stall.req_ready", {63'd0, req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_val("stall.ack_valid", {63'd0, rsp_valid}, 64'd0);
    check_val("stall.ack_ready", {63'd0, req_ready}, 64'd1);
    // Waiting reserved request is accepted on this edge
    step();
    req_valid = 1'b0;
    check_val("rsv.lo_cmd", {60'd0, alu_exe_cmd}, 64'd0);
    check_val("rsv.lo_busy", {63'd0, req_ready}, 64'd0);
    step();
    check_val("rsv.hi_cmd", {60'd0, alu_exe_cmd}, 64'd0);
    step();
    check_val("rsv.valid", {63'd0, rsp_valid}, 64'd1);
    check_val("rsv.err", {63'd0, rsp_err}, 64'd1);
    check_val("rsv.result", rsp_result, 64'd0);
    check_val("rsv.status", {60'd0, rsp_status}, 64'h4);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset pulsed in the HI pass discards the request immediately
    req_op    = 3'b000;
    req_a     = 64'h0000_0000_FFFF_FFFF;
    req_b     = 64'h0000_0000_0000_0001;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    check_val("rst.in_hi", {60'd0, alu_exe_cmd}, 64'h3);
    rst = 1'b1;
    #1;
    check_val("rst.valid", {63'd0, rsp_valid}, 64'd0);
    check_val("rst.cmd", {60'd0, alu_exe_cmd}, 64'd0);
    check_val("rst.result", rsp_result, 64'd0);
    check_val("rst.err", {63'd0, rsp_err}, 64'd0);
    step();
    rst = 1'b0;
    step();
    check_val("rst.req_ready", {63'd0, req_ready}, 64'd1);
    check_val("rst.still_idle", {63'd0, rsp_valid}, 64'd0);
    run_op("add_2_3", 3'b000, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0003,
           4'b0010, 4'b0011, 1'b0, 64'h0000_0000_0000_0005, 4'b0000, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
